// File: rtl/full_subtractor_if.sv
// Signal bundle for the single-bit full subtractor: operand/borrow inputs with
// their qualifier, plus the combinational and registered results.
interface full_subtractor_if;
    logic a0;
    logic a1;
    logic bin;
    logic in_valid;
    logic chain;
    logic d;
    logic bout;
    logic d_q;
    logic bout_q;
    logic out_valid;
    logic borrow_q;

    modport master (
        output a0, a1, bin, in_valid, chain,
        input  d, bout, d_q, bout_q, out_valid, borrow_q
    );

    modport slave (
        input  a0, a1, bin, in_valid, chain,
        output d, bout, d_q, bout_q, out_valid, borrow_q
    );
endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor (a0 - a1 - borrow) with a registered result stage.
// Build option FS_CHAIN_EN: chain selects the internal borrow register as borrow-in.
module full_subtractor (
    input  logic            clk,
    input  logic            rst_n,
    full_subtractor_if.slave fs
);

    logic bin_eff;
    logic diff;
    logic borrow;

    logic d_d;
    logic bout_d;
    logic borrow_d;
    logic out_valid_d;

    logic d_q;
    logic bout_q;
    logic borrow_q;
    logic out_valid_q;

`ifdef FS_CHAIN_EN
    // A held borrow register keeps chain=1 free of X even when bin is left floating.
    assign bin_eff = fs.chain ? borrow_q : fs.bin;
`else
    assign bin_eff = fs.bin;
`endif

    always_comb begin
        diff   = fs.a0 ^ fs.a1 ^ bin_eff;
        borrow = (~fs.a0 & fs.a1) | (~(fs.a0 ^ fs.a1) & bin_eff);
    end

    always_comb begin
        d_d         = d_q;
        bout_d      = bout_q;
        borrow_d    = borrow_q;
        out_valid_d = 1'b0;
        if (fs.in_valid) begin
            d_d         = diff;
            bout_d      = borrow;
            borrow_d    = borrow;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= 1'b0;
            bout_q      <= 1'b0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            bout_q      <= bout_d;
            borrow_q    <= borrow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign fs.d         = diff;
    assign fs.bout      = borrow;
    assign fs.d_q       = d_q;
    assign fs.bout_q    = bout_q;
    assign fs.borrow_q  = borrow_q;
    assign fs.out_valid = out_valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor: random stimulus against an
// arithmetic reference model, plus directed serial and reset scenarios.
module tb_full_subtractor;

    logic clk;
    logic rst_n;
    full_subtractor_if fs ();

    full_subtractor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fs    (fs.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // reference state
    logic m_d_q, m_bout_q, m_borrow_q, m_out_valid;
    logic e_d, e_bout;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // a0 - a1 - borrow as signed integers: difference bit is the LSB, borrow is the sign
    task automatic model_comb(input logic a0, input logic a1, input logic bin, input logic ch);
        int   diff;
        logic be;
`ifdef FS_CHAIN_EN
        be = ch ? m_borrow_q : bin;
`else
        be = bin;
`endif
        diff   = int'(a0) - int'(a1) - int'(be);
        e_d    = diff[0];
        e_bout = (diff < 0);
    endtask

    task automatic model_reset();
        m_d_q = 0; m_bout_q = 0; m_borrow_q = 0; m_out_valid = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".d_q"},       fs.d_q,       m_d_q);
        chk({tag, ".bout_q"},    fs.bout_q,    m_bout_q);
        chk({tag, ".borrow_q"},  fs.borrow_q,  m_borrow_q);
        chk({tag, ".out_valid"}, fs.out_valid, m_out_valid);
    endtask

    // One cycle: drive at negedge, check combinational outputs, clock, check registers.
    task automatic step(input string tag, input logic a0, input logic a1, input logic bin,
                        input logic ch, input logic v);
        @(negedge clk);
        fs.a0 = a0; fs.a1 = a1; fs.bin = bin; fs.chain = ch; fs.in_valid = v;
        #1;
        model_comb(a0, a1, bin, ch);
        chk({tag, ".d"},    fs.d,    e_d);
        chk({tag, ".bout"}, fs.bout, e_bout);
        @(posedge clk);
        #1;
        if (v) begin
            m_d_q = e_d; m_bout_q = e_bout; m_borrow_q = e_bout; m_out_valid = 1;
        end else begin
            m_out_valid = 0;
        end
        check_regs(tag);
    endtask

    initial begin
        rst_n = 0;
        fs.a0 = 0; fs.a1 = 0; fs.bin = 0; fs.chain = 0; fs.in_valid = 0;
        model_reset();
        #22;
        check_regs("reset");
        rst_n = 1;

        // exhaustive combinational sweep against the truth table
        begin
            logic [1:0] tt [8];
            tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b01;
            tt[4] = 2'b10; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;
            for (int i = 0; i < 8; i++) begin
                logic [2:0] v;
                v = 3'(i);
                @(negedge clk);
                fs.a0 = v[2]; fs.a1 = v[1]; fs.bin = v[0]; fs.chain = 0; fs.in_valid = 0;
                #1;
                chk("sweep.d",    fs.d,    tt[i][1]);
                chk("sweep.bout", fs.bout, tt[i][0]);
            end
        end

        // registered path and hold
        step("reg_cap", 0, 0, 1, 0, 1);
        chk("reg_cap.dq_const", fs.d_q, 1'b1);
        chk("reg_cap.bq_const", fs.bout_q, 1'b1);
        step("reg_hold", 1, 0, 0, 0, 0);
        chk("reg_hold.dq_const", fs.d_q, 1'b1);
        chk("reg_hold.ov_const", fs.out_valid, 1'b0);

`ifdef FS_CHAIN_EN
        // 5 - 3 = 2, LSB first
        step("s53_b0", 1, 1, 0, 0, 1); chk("s53_b0.dq", fs.d_q, 1'b0);
        step("s53_b1", 0, 1, 0, 1, 1); chk("s53_b1.dq", fs.d_q, 1'b1);
        step("s53_b2", 1, 0, 0, 1, 1); chk("s53_b2.dq", fs.d_q, 1'b0);
        chk("s53.neg", fs.bout_q, 1'b0);
        // 2 - 3 -> negative
        step("s23_b0", 0, 1, 0, 0, 1); chk("s23_b0.dq", fs.d_q, 1'b1);
        step("s23_b1", 1, 1, 0, 1, 1); chk("s23_b1.dq", fs.d_q, 1'b1);
        chk("s23.neg", fs.bout_q, 1'b1);
`endif

        // chain=1 with borrow_q=1, a0=a1=bin=0
        step("prep_borrow", 0, 1, 0, 0, 1);
        chk("prep_borrow.bq", fs.borrow_q, 1'b1);
        @(negedge clk);
        fs.a0 = 0; fs.a1 = 0; fs.bin = 0; fs.chain = 1; fs.in_valid = 0;
        #1;
`ifdef FS_CHAIN_EN
        chk("chain_on.d",    fs.d,    1'b1);
        chk("chain_on.bout", fs.bout, 1'b1);
`else
        chk("chain_off.d",    fs.d,    1'b0);
        chk("chain_off.bout", fs.bout, 1'b0);
`endif

        // asynchronous reset mid serial operation
        step("pre_rst0", 1, 1, 1, 0, 1);
        step("pre_rst1", 0, 1, 0, 1, 1);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_regs("async_rst");
        fs.a0 = 0; fs.a1 = 0; fs.bin = 1; fs.chain = 1;
        #1;
        model_comb(0, 0, 1, 1);
        chk("rst_comb.d",    fs.d,    e_d);
        chk("rst_comb.bout", fs.bout, e_bout);
        @(negedge clk);
        rst_n = 1;

        // chain=1 right after reset is legal and uses borrow 0
        step("post_rst_chain", 1, 0, 1, 1, 1);

        // random stimulus against the model
        for (int k = 0; k < 300; k++) begin
            logic [4:0] r;
            r = 5'($urandom_range(0, 31));
            step("rand", r[0], r[1], r[2], r[3], r[4] | r[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
